// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the asynchronous FIFO: read pointer, write-pointer synchroniser,
// registered empty/almost-empty/count flags and a sticky underflow flag, all in clk_r.
module fifo_read_ctrl #(
  parameter int unsigned depth       = 8,
  parameter int unsigned adr_width   = $clog2(depth),
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_THRESH   = 2
) (
  input  logic                 clk_r,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [adr_width:0]   wr_ptr_gray,
  output logic                 read,
  output logic [adr_width-1:0] read_adr,
  output logic [adr_width:0]   rd_ptr_gray,
  output logic                 FIFO_empty,
  output logic                 almost_empty,
  output logic [adr_width:0]   rd_count,
  output logic                 underflow
);

  localparam int unsigned PW = adr_width + 1;
  localparam logic [PW-1:0] AeThresh = PW'(AE_THRESH);

  logic [PW-1:0] rbin_q, rbin_d, gray_d;
  logic [PW-1:0] wq_q [SYNC_STAGES];
  logic [PW-1:0] wq_s, wbin_s, count_d;
  logic          en;

  assign en       = rd_en & ~FIFO_empty;
  assign read     = en;
  assign read_adr = rbin_q[adr_width-1:0];
  assign wq_s     = wq_q[SYNC_STAGES-1];

  always_comb begin
    rbin_d = rbin_q + PW'(en);
    gray_d = rbin_d ^ (rbin_d >> 1);
    // Gray to binary: each bit is the XOR of all Gray bits at or above it.
    wbin_s = '0;
    for (int i = 0; i < int'(PW); i++) begin
      wbin_s[i] = ^(wq_s >> i);
    end
    count_d = wbin_s - rbin_d;
  end

  // Plain flop chain; wr_ptr_gray lands directly in the first stage.
  always_ff @(posedge clk_r) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        wq_q[i] <= '0;
      end
    end else begin
      wq_q[0] <= wr_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        wq_q[i] <= wq_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_r) begin
    if (reset) begin
      rbin_q       <= '0;
      rd_ptr_gray  <= '0;
      FIFO_empty   <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rd_ptr_gray  <= gray_d;
      FIFO_empty   <= (gray_d == wq_s);
      almost_empty <= (count_d <= AeThresh);
      rd_count     <= count_d;
      underflow    <= underflow | (rd_en & FIFO_empty);
    end
  end

endmodule
